// File: rtl/load_store_pipe_pkg.sv
// Shared definitions for the load/store pipe ownership logic.
//   - ownerState_t  : states of the pipe-owner scheduler
//   - L_SEL_*       : arbiter select encodings (execution vs exception)
//   - ldstOrder_t   : access-size encodings used by load/store requesters
//   - isExceptOwner : true while the exception side holds the arbiter select
package load_store_pipe_pkg;

  typedef enum logic [1:0] {
    EXE_OWN   = 2'b00,
    EXE_DRAIN = 2'b01,
    EXC_OWN   = 2'b10,
    EXC_DRAIN = 2'b11
  } ownerState_t;

  localparam logic L_SEL_EXE    = 1'b0;
  localparam logic L_SEL_EXCEPT = 1'b1;

  typedef enum logic [1:0] {
    ORDER_BYTE = 2'b00,
    ORDER_HALF = 2'b01,
    ORDER_WORD = 2'b10,
    ORDER_NONE = 2'b11
  } ldstOrder_t;

  // The select stays on the exception side through its drain phase so that
  // late responses still return to the exception unit.
  function automatic logic isExceptOwner(input ownerState_t s);
    return (s == EXC_OWN) || (s == EXC_DRAIN);
  endfunction

endpackage

// File: rtl/ldst_outstanding_counter.sv
// Up/down saturating counter of in-flight load/store transactions.
// Ports:
//   clock_i, reset_i : clock and synchronous active-high reset
//   issue_i          : one transaction accepted by the pipe this cycle
//   valid_i          : one response returned by the pipe this cycle
//   cnt_o            : registered in-flight count
//   full_o           : registered count equals P_MAX_OUTSTANDING
//   nextZero_o       : count after this edge will be zero
//   err_o            : protocol violation this cycle (issue while full,
//                      or response with nothing in flight)
module ldst_outstanding_counter #(
  parameter int P_MAX_OUTSTANDING = 4,
  parameter int P_CNT_W           = $clog2(P_MAX_OUTSTANDING + 1)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               issue_i,
  input  logic               valid_i,
  output logic [P_CNT_W-1:0] cnt_o,
  output logic               full_o,
  output logic               nextZero_o,
  output logic               err_o
);

  logic [P_CNT_W-1:0] cnt_q;
  logic [P_CNT_W-1:0] cnt_d;

  assign full_o = (cnt_q == P_CNT_W'(P_MAX_OUTSTANDING));

  // Issue and response together cancel out, even at zero, since a
  // zero-latency return is legal. A lone issue at the limit or a lone
  // response at zero leaves the count alone and flags an error instead.
  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    case ({issue_i, valid_i})
      2'b10: begin
        if (full_o) err_o = 1'b1;
        else        cnt_d = cnt_q + P_CNT_W'(1);
      end
      2'b01: begin
        if (cnt_q == '0) err_o = 1'b1;
        else             cnt_d = cnt_q - P_CNT_W'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  assign nextZero_o = (cnt_d == '0);

  // Count register.
  always_ff @(posedge clock_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/load_store_pipe_owner_scheduler.sv
// Owner scheduler for the shared load/store pipe. Drives the arbiter select
// between the execution unit and the exception unit, and only hands the pipe
// over once every in-flight transaction has returned, so each response goes
// back to the unit that issued it. Either owner is also held while the
// outstanding limit is reached.
// Ports:
//   iCLOCK, iRESET_SYNC : clock and synchronous active-high reset
//   iEXCEPT_WANT        : exception unit requests ownership (level)
//   iEXCEPT_RELEASE     : exception unit returns ownership (pulse)
//   oEXCEPT_GRANT       : exception unit owns the pipe
//   oEXCEPT_HOLD        : exception unit must not issue
//   oEXE_HOLD           : execution unit must not issue
//   iLDST_REQ/BUSY/VALID: pipe request, busy and response strobes
//   oUSE_SEL            : arbiter select, 0 = execution, 1 = exception
//   oOUTSTANDING        : in-flight transaction count
//   oERR_PROTOCOL       : sticky counter protocol error
module load_store_pipe_owner_scheduler
  import load_store_pipe_pkg::*;
#(
  parameter int P_MAX_OUTSTANDING = 4,
  parameter int P_CNT_W           = $clog2(P_MAX_OUTSTANDING + 1)
) (
  input  logic               iCLOCK,
  input  logic               iRESET_SYNC,
  input  logic               iEXCEPT_WANT,
  input  logic               iEXCEPT_RELEASE,
  output logic               oEXCEPT_GRANT,
  output logic               oEXCEPT_HOLD,
  output logic               oEXE_HOLD,
  input  logic               iLDST_REQ,
  input  logic               iLDST_BUSY,
  input  logic               iLDST_VALID,
  output logic               oUSE_SEL,
  output logic [P_CNT_W-1:0] oOUTSTANDING,
  output logic               oERR_PROTOCOL
);

  ownerState_t        state_q;
  ownerState_t        state_d;
  logic               errProtocol_q;
  logic               resetSeen_q;
  logic               issue;
  logic               cntFull;
  logic               cntNextZero;
  logic               cntErr;
  logic [P_CNT_W-1:0] cnt;

  assign issue = iLDST_REQ & ~iLDST_BUSY;

  ldst_outstanding_counter #(
    .P_MAX_OUTSTANDING(P_MAX_OUTSTANDING),
    .P_CNT_W          (P_CNT_W)
  ) uCounter (
    .clock_i   (iCLOCK),
    .reset_i   (iRESET_SYNC),
    .issue_i   (issue),
    .valid_i   (iLDST_VALID),
    .cnt_o     (cnt),
    .full_o    (cntFull),
    .nextZero_o(cntNextZero),
    .err_o     (cntErr)
  );

  // Ownership state register plus the sticky error flag. resetSeen_q keeps
  // every output quiet in the cycle following a sampled reset, so the whole
  // interface reads as zero while reset is held, without any combinational
  // path from the reset input.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q       <= EXE_OWN;
      errProtocol_q <= 1'b0;
      resetSeen_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      errProtocol_q <= errProtocol_q | cntErr;
      resetSeen_q   <= 1'b0;
    end
  end

  // Next-state logic. Both drain states look at the count after this edge so
  // that a response arriving in the last drain cycle lets the handoff happen
  // on the same edge. Wanting the pipe while the exception side already owns
  // it, or releasing it while not owning it, has no effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EXE_OWN: begin
        if (iEXCEPT_WANT) state_d = EXE_DRAIN;
      end
      EXE_DRAIN: begin
        if (!iEXCEPT_WANT)    state_d = EXE_OWN;
        else if (cntNextZero) state_d = EXC_OWN;
      end
      EXC_OWN: begin
        if (iEXCEPT_RELEASE) state_d = EXC_DRAIN;
      end
      EXC_DRAIN: begin
        if (cntNextZero) state_d = EXE_OWN;
      end
      default: state_d = EXE_OWN;
    endcase
  end

  // Outputs depend only on registered state and count.
  always_comb begin
    oUSE_SEL      = L_SEL_EXE;
    oEXCEPT_GRANT = 1'b0;
    oEXE_HOLD     = 1'b0;
    oEXCEPT_HOLD  = 1'b0;
    if (!resetSeen_q) begin
      oUSE_SEL      = isExceptOwner(state_q) ? L_SEL_EXCEPT : L_SEL_EXE;
      oEXCEPT_GRANT = (state_q == EXC_OWN);
      oEXE_HOLD     = (state_q != EXE_OWN) | cntFull;
      oEXCEPT_HOLD  = (state_q != EXC_OWN) | cntFull;
    end
  end

  assign oOUTSTANDING  = cnt;
  assign oERR_PROTOCOL = errProtocol_q;

endmodule

// File: doc/load_store_pipe_owner_scheduler.md
Name: load_store_pipe_owner_scheduler

Overview:
- Sequential owner scheduler for the shared load/store pipe.
- Drives the execution/exception select into the load/store pipe arbiter.
- Hands the pipe between the execution unit and the exception unit only when no transactions are in flight, so every iLDST_VALID returns to the requester that issued it.
- Also stalls the current owner when the outstanding-transaction limit is reached.

Parameters:
- P_MAX_OUTSTANDING, 4, maximum in-flight load/store transactions; must be >= 1.
- P_CNT_W, $clog2(P_MAX_OUTSTANDING+1), outstanding-counter width (derived; do not override).

Ports:
- iCLOCK  in  1  core clock
- iRESET_SYNC  in  1  synchronous reset, active high
- iEXCEPT_WANT  in  1  exception unit requests pipe ownership (level; hold until oEXCEPT_GRANT)
- iEXCEPT_RELEASE  in  1  exception unit returns ownership (1-cycle pulse, honoured only in EXC_OWN)
- oEXCEPT_GRANT  out  1  exception unit owns the pipe and may issue
- oEXCEPT_HOLD  out  1  exception unit must not issue (treated as busy)
- oEXE_HOLD  out  1  execution unit must not issue (treated as busy)
- iLDST_REQ  in  1  muxed request presented to the load/store pipe
- iLDST_BUSY  in  1  load/store pipe busy
- iLDST_VALID  in  1  load/store pipe returns one response
- oUSE_SEL  out  1  arbiter select: 0 = execution, 1 = exception
- oOUTSTANDING  out  P_CNT_W  current in-flight count
- oERR_PROTOCOL  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (synchronous, active high):
  - state = EXE_OWN, counter = 0.
  - oUSE_SEL = 0, oEXCEPT_GRANT = 0, oEXE_HOLD = 0, oEXCEPT_HOLD = 0, oERR_PROTOCOL = 0.
  - Reset mid-operation discards all state. The load/store pipe is reset on the same edge.
- Outstanding counter:
  - issue = iLDST_REQ & ~iLDST_BUSY.
  - next = cnt + issue − iLDST_VALID.
  - issue and valid in the same cycle: count unchanged, including at cnt = 0 (zero-latency return is legal).
  - Valid with cnt = 0 and no issue: count stays 0; set oERR_PROTOCOL.
  - Issue with cnt = P_MAX_OUTSTANDING and no valid: count saturates; set oERR_PROTOCOL.
- State machine (registered):
  - EXE_OWN: sel 0. If iEXCEPT_WANT, go to EXE_DRAIN.
  - EXE_DRAIN: sel 0, exe held.
    - Next-cycle count = 0 and iEXCEPT_WANT: go to EXC_OWN.
    - iEXCEPT_WANT deasserted: return to EXE_OWN (abort).
  - EXC_OWN: sel 1, grant 1. On iEXCEPT_RELEASE, go to EXC_DRAIN.
  - EXC_DRAIN: sel 1, grant 0, exception held. When next-cycle count = 0, go to EXE_OWN.
- Output derivation (all from registered state and count; no combinational path from inputs):
  - oUSE_SEL = state ∈ {EXC_OWN, EXC_DRAIN}.
  - oEXCEPT_GRANT = (state == EXC_OWN).
  - oEXE_HOLD = (state != EXE_OWN) | (cnt == P_MAX_OUTSTANDING).
  - oEXCEPT_HOLD = (state != EXC_OWN) | (cnt == P_MAX_OUTSTANDING).
- Timing and latency:
  - A request issued in the same cycle iEXCEPT_WANT first rises is counted and drained.
  - WANT→GRANT latency with no traffic: 2 cycles (EXE_OWN→EXE_DRAIN→EXC_OWN).
  - RELEASE→sel 0 with no traffic: 2 cycles.
  - oUSE_SEL never changes while cnt ≠ 0.
- Simultaneous events:
  - iEXCEPT_RELEASE outside EXC_OWN is ignored.
  - iEXCEPT_WANT in EXC_OWN/EXC_DRAIN is ignored.

Decomposition:
- Shared package load_store_pipe_pkg:
  - state enum (EXE_OWN, EXE_DRAIN, EXC_OWN, EXC_DRAIN).
  - Select constants (L_SEL_EXE = 0, L_SEL_EXCEPT = 1).
  - Order encodings (byte/2-byte/word/none).
- Sub-module ldst_outstanding_counter:
  - up/down saturating counter.
  - Outputs: cnt, full, next-is-zero, error pulse.
- FSM and hold logic remain in the top.

Test Plan:
- Reset: assert iRESET_SYNC for 2 cycles with random inputs -> all outputs 0, oOUTSTANDING = 0.
- Exe drains to exception handoff:
  - 3 exe issues (BUSY = 0), then iEXCEPT_WANT = 1 -> oEXE_HOLD = 1 next cycle, oUSE_SEL stays 0.
  - 3 VALIDs on separate cycles -> oEXCEPT_GRANT = 1 and oUSE_SEL = 1 one cycle after the last VALID.
- Release with traffic:
  - In EXC_OWN, issue 1, then RELEASE pulse -> oEXCEPT_HOLD = 1, oUSE_SEL = 1 until VALID.
  - Then oUSE_SEL = 0, oEXE_HOLD = 0.
- Saturation (P_MAX_OUTSTANDING = 4):
  - 4 exe issues without return -> oEXE_HOLD = 1 at cnt = 4.
  - 1 VALID -> cnt 3, oEXE_HOLD = 0.
  - Forced 5th issue at cnt 4 -> oERR_PROTOCOL = 1, cnt stays 4.
- Counter corners:
  - Issue and VALID together at cnt 2 -> cnt stays 2.
  - VALID alone at cnt 0 -> oERR_PROTOCOL = 1, cnt 0.
- Abort and reset:
  - iEXCEPT_WANT dropped during EXE_DRAIN with cnt 1 -> EXE_OWN next cycle, oEXE_HOLD = 0, no grant.
  - iRESET_SYNC during EXC_OWN -> oUSE_SEL = 0 next cycle.
